// File: rtl/meco_command_writer_pkg.sv
// Shared types and constants for the command mailbox (writer and command processor side).
package meco_cmd_pkg;

  localparam int CMD_ADDR_W = 21;
  localparam int CMD_DATA_W = 16;

  localparam logic [CMD_ADDR_W-1:0] DEF_INSTR_ADDR   = 21'h00000F;
  localparam logic [CMD_ADDR_W-1:0] DEF_PAYLOAD_BASE = 21'h000010;

  // Header word layout, must match the command processor's decoder.
  // A header of all zeros means "mailbox empty" and is never committed.
  localparam int HDR_OPCODE_LSB = 8;
  localparam int HDR_OPCODE_W   = 8;
  localparam int HDR_LEN_LSB    = 0;
  localparam int HDR_LEN_W      = 8;
  localparam logic [CMD_DATA_W-1:0] HDR_EMPTY = '0;

  // state      | meaning
  // ST_IDLE    | waiting for a header word
  // ST_LOAD    | streaming payload words into RAM
  // ST_DRAIN   | packet overflowed, discarding until last word
  // ST_COMMIT  | writing header to the mailbox word
  // ST_WAIT    | idle gap between mailbox polls
  // ST_POLL_RD | issuing mailbox read
  // ST_POLL_CHK| checking read data for clear
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_COMMIT,
    ST_WAIT,
    ST_POLL_RD,
    ST_POLL_CHK
  } state_t;

endpackage

// File: rtl/meco_command_writer_if.sv
// Command stream + RAM port bundle. master = command writer, slave = stream source / RAM side.
interface meco_command_writer_if
  import meco_cmd_pkg::*;
#(
  parameter int ADDR_W = CMD_ADDR_W,
  parameter int DATA_W = CMD_DATA_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_last;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data_out;
  logic [DATA_W-1:0] ram_data_in;
  logic              ram_en;
  logic              ram_wr;

  modport master (
    input  cmd_valid, cmd_data, cmd_last, ram_data_in,
    output cmd_ready, ram_addr, ram_data_out, ram_en, ram_wr
  );

  modport slave (
    output cmd_valid, cmd_data, cmd_last, ram_data_in,
    input  cmd_ready, ram_addr, ram_data_out, ram_en, ram_wr
  );

endinterface

// File: rtl/meco_command_writer.sv
// Producer side of the shared-RAM command mailbox: payload first, header last, then poll for clear.
// Optional build macro MECO_CMDWR_TIMEOUT_EN adds a poll timeout that aborts the mailbox entry.
module meco_command_writer
  import meco_cmd_pkg::*;
#(
  parameter int                ADDR_W       = CMD_ADDR_W,
  parameter int                DATA_W       = CMD_DATA_W,
  parameter logic [ADDR_W-1:0] INSTR_ADDR   = ADDR_W'(DEF_INSTR_ADDR),
  parameter logic [ADDR_W-1:0] PAYLOAD_BASE = ADDR_W'(DEF_PAYLOAD_BASE),
  parameter int                MAX_WORDS    = 8,
  parameter int                POLL_GAP     = 4,
  parameter int                TIMEOUT_CYC  = 4096
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  meco_command_writer_if.master bus,
  output logic                 busy_o,
  output logic                 err_o
);

  if (MAX_WORDS < 1 || POLL_GAP < 0 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("meco_command_writer: illegal parameter value");
  end

  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WORDS);

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
  // With no gap configured, skip ST_WAIT entirely instead of spending one cycle there.
  localparam state_t ST_AFTER_POLL = (POLL_GAP == 0) ? ST_POLL_RD : ST_WAIT;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   hdr_q, hdr_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                err_q, err_d;

  logic                cmd_ready;
  logic                ram_en;
  logic                ram_wr;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_data_out;

  logic cmd_acc;
  logic cnt_full;
  logic poll_clear;
  logic tmo_abort;

  assign cmd_acc    = bus.cmd_valid && cmd_ready;
  assign cnt_full   = (cnt_q == CNT_MAX);
  assign poll_clear = (bus.ram_data_in == '0);

`ifdef MECO_CMDWR_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             polling;

  assign polling = (state_q == ST_WAIT) || (state_q == ST_POLL_RD) || (state_q == ST_POLL_CHK);
  // A clear seen on the very cycle the timer expires still counts as a normal completion.
  assign tmo_abort = polling && (tmo_q == '0) && !((state_q == ST_POLL_CHK) && poll_clear);

  // Poll timeout down-counter, loaded when the header is committed.
  always_ff @(posedge clk_i) begin
    if (reset_i) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end

  // Timeout counter next value.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == ST_COMMIT)        tmo_d = TMO_LOAD;
    else if (polling && tmo_q != '0) tmo_d = tmo_q - 1'b1;
  end
`else
  assign tmo_abort = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hdr_q   <= '0;
      gap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath next values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    gap_d   = gap_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_acc) begin
          hdr_d   = bus.cmd_data;
          cnt_d   = '0;
          state_d = bus.cmd_last ? ST_COMMIT : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (cmd_acc) begin
          if (cnt_full) begin
            err_d   = 1'b1;
            // Overflow on the last word needs no draining.
            state_d = bus.cmd_last ? ST_IDLE : ST_DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (bus.cmd_last) state_d = ST_COMMIT;
          end
        end
      end
      ST_DRAIN: begin
        if (cmd_acc && bus.cmd_last) state_d = ST_IDLE;
      end
      ST_COMMIT: begin
        gap_d = GAP_LOAD;
        if (hdr_q == HDR_EMPTY[DATA_W-1:0]) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_AFTER_POLL;
        end
      end
      ST_WAIT: begin
        if (gap_q == '0) state_d = ST_POLL_RD;
        else             gap_d   = gap_q - 1'b1;
      end
      ST_POLL_RD: state_d = ST_POLL_CHK;
      ST_POLL_CHK: begin
        gap_d   = GAP_LOAD;
        state_d = poll_clear ? ST_IDLE : ST_AFTER_POLL;
      end
      default: state_d = ST_IDLE;
    endcase
    if (tmo_abort) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end
  end

  // Stream handshake and RAM port; everything is held quiet while reset is asserted.
  always_comb begin
    cmd_ready    = 1'b0;
    ram_en       = 1'b0;
    ram_wr       = 1'b0;
    ram_addr     = INSTR_ADDR;
    ram_data_out = '0;
    if (!reset_i) begin
      unique case (state_q)
        ST_IDLE, ST_DRAIN: cmd_ready = 1'b1;
        ST_LOAD: begin
          cmd_ready = 1'b1;
          if (bus.cmd_valid && !cnt_full) begin
            ram_en       = 1'b1;
            ram_wr       = 1'b1;
            ram_addr     = PAYLOAD_BASE + ADDR_W'(cnt_q);
            ram_data_out = bus.cmd_data;
          end
        end
        ST_COMMIT: begin
          if (hdr_q != HDR_EMPTY[DATA_W-1:0]) begin
            ram_en       = 1'b1;
            ram_wr       = 1'b1;
            ram_data_out = hdr_q;
          end
        end
        ST_POLL_RD: ram_en = 1'b1;
        default: ;
      endcase
      // Abort clears the mailbox so the processor never picks up a stale command.
      if (tmo_abort) begin
        ram_en       = 1'b1;
        ram_wr       = 1'b1;
        ram_addr     = INSTR_ADDR;
        ram_data_out = '0;
      end
    end
  end

  assign bus.cmd_ready    = cmd_ready;
  assign bus.ram_en       = ram_en;
  assign bus.ram_wr       = ram_wr;
  assign bus.ram_addr     = ram_addr;
  assign bus.ram_data_out = ram_data_out;

  assign busy_o = !reset_i && (state_q != ST_IDLE);
  assign err_o  = err_q;

endmodule

// File: tb/tb_meco_command_writer.sv
// Directed bench for meco_command_writer with a small RAM / command-processor model.
module tb_meco_command_writer;
  import meco_cmd_pkg::*;

  localparam int AW   = 21;
  localparam int DW   = 16;
  localparam int MAXW = 8;
  localparam int GAP  = 4;
  localparam int TMO  = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy, err;

  always #5 clk = ~clk;

  meco_command_writer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  meco_command_writer #(
    .ADDR_W(AW), .DATA_W(DW),
    .INSTR_ADDR(21'h00000F), .PAYLOAD_BASE(21'h000010),
    .MAX_WORDS(MAXW), .POLL_GAP(GAP), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_i(clk), .reset_i(reset), .bus(bus), .busy_o(busy), .err_o(err)
  );

  // RAM model: logs writes and mailbox reads; clears the mailbox once poll_total reaches clear_at.
  logic [15:0] mem [0:63];
  logic [15:0] rd_q = '0;
  int cyc = 0;
  int poll_total = 0;
  int clear_at = 0;
  int wa[$];
  int wd[$];
  int wc[$];
  int rlog[$];

  assign bus.ram_data_in = rd_q;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.ram_en && bus.ram_wr) begin
      wa.push_back(int'(bus.ram_addr));
      wd.push_back(int'(bus.ram_data_out));
      wc.push_back(cyc);
      mem[bus.ram_addr[5:0]] <= bus.ram_data_out;
    end else if (bus.ram_en) begin
      if (bus.ram_addr == 21'h00000F) begin
        rlog.push_back(cyc);
        poll_total <= poll_total + 1;
        if (poll_total >= clear_at) begin
          rd_q    <= '0;
          mem[15] <= '0;
        end else begin
          rd_q <= mem[15];
        end
      end else begin
        rd_q <= mem[bus.ram_addr[5:0]];
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int pkt[$];
  int last_acc = 0;

  task automatic send_pkt(input bit with_last);
    for (int i = 0; i < pkt.size(); i++) begin
      int t;
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = 16'(pkt[i]);
      bus.cmd_last  = with_last && (i == pkt.size() - 1);
      t = 0;
      while (!bus.cmd_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk("word_ready", int'(bus.cmd_ready), 1);
      @(posedge clk);
      last_acc = cyc;
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("idle_reached", int'(busy), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w0, r0, nf;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.cmd_last  = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(bus.cmd_ready), 0);
    chk("rst_en", int'(bus.ram_en), 0);
    chk("rst_wr", int'(bus.ram_wr), 0);
    chk("rst_addr", int'(bus.ram_addr), 'hF);
    chk("rst_dout", int'(bus.ram_data_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", int'(bus.cmd_ready), 1);

    // 1: header + 2 payload words, mailbox cleared after 3 polls
    clear_at = poll_total + 3;
    w0 = wa.size();
    r0 = rlog.size();
    pkt = '{'h0102, 'hAAAA, 'hBBBB};
    send_pkt(1'b1);
    chk("p1_busy", int'(busy), 1);
    chk("p1_ready_commit", int'(bus.cmd_ready), 0);
    @(negedge clk);
    chk("p1_nwr", wa.size() - w0, 3);
    if (wa.size() >= w0 + 3) begin
      chk("p1_a0", wa[w0], 'h10);
      chk("p1_d0", wd[w0], 'hAAAA);
      chk("p1_a1", wa[w0+1], 'h11);
      chk("p1_d1", wd[w0+1], 'hBBBB);
      chk("p1_nobubble", wc[w0+1] - wc[w0], 1);
      chk("p1_ahdr", wa[w0+2], 'hF);
      chk("p1_dhdr", wd[w0+2], 'h0102);
      chk("p1_hdr_lat", wc[w0+2] - last_acc, 1);
    end

    // 2: poll until clear
    wait_idle();
    chk("p2_ready", int'(bus.cmd_ready), 1);
    chk("p2_npoll", rlog.size() - r0, 4);
    if (rlog.size() >= r0 + 2 && wa.size() >= w0 + 3) begin
      chk("p2_first_poll", rlog[r0] - wc[w0+2], GAP + 1);
      chk("p2_poll_gap", rlog[r0+1] - rlog[r0], GAP + 2);
    end
    chk("p2_err", int'(err), 0);

    // 3: single-word packet
    clear_at = poll_total;
    w0 = wa.size();
    pkt = '{'h0005};
    send_pkt(1'b1);
    @(negedge clk);
    chk("p3_nwr", wa.size() - w0, 1);
    if (wa.size() >= w0 + 1) begin
      chk("p3_addr", wa[w0], 'hF);
      chk("p3_data", wd[w0], 'h0005);
      chk("p3_lat", wc[w0] - last_acc, 1);
    end
    wait_idle();

    // 4: overflow, 9 payload words
    w0 = wa.size();
    pkt = '{'h0123};
    for (int i = 0; i < 9; i++) pkt.push_back('h1000 + i);
    send_pkt(1'b1);
    chk("p4_busy", int'(busy), 0);
    chk("p4_err", int'(err), 1);
    chk("p4_nwr", wa.size() - w0, 8);
    nf = 0;
    for (int i = 0; i < 8; i++) begin
      if (wa.size() > w0 + i) begin
        chk("p4_addr", wa[w0+i], 'h10 + i);
        chk("p4_data", wd[w0+i], 'h1000 + i);
      end
    end
    for (int i = w0; i < wa.size(); i++) if (wa[i] == 'hF) nf++;
    chk("p4_no_commit", nf, 0);

    // 5: zero header, then reset mid-LOAD
    pulse_reset();
    chk("p5_err_cleared", int'(err), 0);
    w0 = wa.size();
    pkt = '{'h0000, 'h5555};
    send_pkt(1'b1);
    repeat (3) @(negedge clk);
    chk("p5_nwr", wa.size() - w0, 1);
    if (wa.size() >= w0 + 1) begin
      chk("p5_addr", wa[w0], 'h10);
      chk("p5_data", wd[w0], 'h5555);
    end
    chk("p5_err", int'(err), 1);
    chk("p5_busy", int'(busy), 0);

    pulse_reset();
    w0 = wa.size();
    pkt = '{'h0777, 'h1111, 'h2222};
    send_pkt(1'b0);
    chk("p5_load_busy", int'(busy), 1);
    reset = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 16'h9999;
    @(negedge clk);
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("p5_rst_nwr", wa.size() - w0, 2);
    chk("p5_rst_err", int'(err), 0);
    chk("p5_rst_busy", int'(busy), 0);

    // 6: mailbox never cleared
    clear_at = poll_total + 1000000;
    w0 = wa.size();
    pkt = '{'h0102};
    send_pkt(1'b1);
`ifdef MECO_CMDWR_TIMEOUT_EN
    begin
      int t;
      t = 0;
      while (!err && t < 300) begin
        @(negedge clk);
        t++;
      end
    end
    chk("p6_err", int'(err), 1);
    chk("p6_busy", int'(busy), 0);
    chk("p6_nwr", wa.size() - w0, 2);
    if (wa.size() >= w0 + 2) begin
      chk("p6_abort_addr", wa[w0+1], 'hF);
      chk("p6_abort_data", wd[w0+1], 0);
    end
`else
    repeat (300) @(negedge clk);
    chk("p6_busy", int'(busy), 1);
    chk("p6_err", int'(err), 0);
    chk("p6_nwr", wa.size() - w0, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
